// File: rtl/gb_cpu_common_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_cpu_common_pkg
// Purpose  : Shared control/schedule types and constants for the CPU core.
// Revision : 1.0  initial release
// ============================================================================
package gb_cpu_common_pkg;

  localparam int SCHED_DEPTH = 6;

  typedef enum logic [2:0] {
    ADDR_ZERO, ADDR_PC, ADDR_SP, ADDR_HL, ADDR_BC, ADDR_DE, ADDR_WZ, ADDR_HIGH_C
  } addr_sel_t;

  typedef enum logic [1:0] {IDU_NOP, IDU_INC, IDU_DEC} idu_op_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR,
    ALU_OR, ALU_CP, ALU_INC, ALU_DEC, ALU_ROT, ALU_BIT
  } alu_op_t;

  typedef enum logic [1:0] {COND_NZ, COND_Z, COND_NC, COND_C} condition_code_t;

  typedef enum logic {S_BOOT, S_EXEC} seq_state_t;

  typedef struct packed {
    addr_sel_t       addr_sel;
    logic            bus_receive;
    logic            bus_drive;
    logic            ir_wren;
    idu_op_t         idu_op;
    logic            idu_to_pc;
    alu_op_t         alu_op;
    logic [3:0]      reg_wr_sel;
    logic            reg_wren;
    logic            flags_wren;
    logic            cc_check;
    condition_code_t cond;
    logic            enable_interrupts;
    logic            disable_interrupts;
  } control_signals_t;

  typedef struct packed {
    logic [2:0]                               m_cycles;
    control_signals_t [SCHED_DEPTH-1:0]       instruction_controls;
    logic                                     cb_prefix_next;
    logic                                     bit_cmd;
  } schedule_t;

  localparam control_signals_t CTRL_NOP = '{
    addr_sel: ADDR_ZERO, bus_receive: 1'b0, bus_drive: 1'b0, ir_wren: 1'b0,
    idu_op: IDU_NOP, idu_to_pc: 1'b0, alu_op: ALU_NOP, reg_wr_sel: 4'd0,
    reg_wren: 1'b0, flags_wren: 1'b0, cc_check: 1'b0, cond: COND_NZ,
    enable_interrupts: 1'b0, disable_interrupts: 1'b0
  };

  // Opcode fetch: PC on the address bus, data into IR, PC incremented by the IDU.
  localparam control_signals_t CTRL_FETCH = '{
    addr_sel: ADDR_PC, bus_receive: 1'b1, bus_drive: 1'b0, ir_wren: 1'b1,
    idu_op: IDU_INC, idu_to_pc: 1'b1, alu_op: ALU_NOP, reg_wr_sel: 4'd0,
    reg_wren: 1'b0, flags_wren: 1'b0, cc_check: 1'b0, cond: COND_NZ,
    enable_interrupts: 1'b0, disable_interrupts: 1'b0
  };

  // flags = {Z,N,H,C}
  function automatic logic checkCondition(input condition_code_t cc, input logic [3:0] flags);
    logic r;
    case (cc)
      COND_NZ: r = !flags[3];
      COND_Z:  r = flags[3];
      COND_NC: r = !flags[0];
      default: r = flags[0];
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gb_cpu_ime_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gb_cpu_ime_ctrl
// Purpose  : Interrupt master enable with the one-instruction EI delay.
// Revision : 1.0  initial release
// ============================================================================
module gb_cpu_ime_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic ei,
  input  logic di,
  input  logic instr_last,
  output logic ime
);

  logic r_ime;
  logic r_ei_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ime     <= 1'b0;
      r_ei_pend <= 1'b0;
    end else if (di) begin
      r_ime     <= 1'b0;
      r_ei_pend <= 1'b0;
    end else begin
      // A pending EI from an earlier instruction completes with this one.
      if (instr_last && r_ei_pend) r_ime <= 1'b1;
      if (ei)              r_ei_pend <= 1'b1;
      else if (instr_last) r_ei_pend <= 1'b0;
    end
  end

  assign ime = r_ime;

endmodule
`default_nettype wire

// File: rtl/gb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gb_cpu_sequencer
// Purpose  : M-cycle sequencer issuing one control word per cycle from the
//            decoder schedule. Optional stall input: GB_CPU_SEQ_STALL_EN.
// Revision : 1.0  initial release
// ============================================================================
module gb_cpu_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter int MAX_SLOTS = SCHED_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  schedule_t        schedule_i,
  input  logic [3:0]       flags_i,
  output control_signals_t ctrl_o,
  output logic             instr_start_o,
  output logic [2:0]       m_cycle_o,
  output logic             cb_mode_o,
  output logic             bit_cmd_o,
  output logic             ime_o
`ifdef GB_CPU_SEQ_STALL_EN
  ,
  input  logic             stall_i
`endif
);

  localparam logic [2:0] C_MAX_MCYC = 3'(MAX_SLOTS);

  function automatic logic [2:0] clamp_mcyc(input logic [2:0] raw);
    if (raw == 3'd0) return 3'd1;
    if (raw > C_MAX_MCYC) return C_MAX_MCYC;
    return raw;
  endfunction

  seq_state_t                       r_state, w_state_nxt;
  logic [2:0]                       r_idx, w_idx_nxt;
  control_signals_t [MAX_SLOTS-1:0] r_sched;
  logic [2:0]                       r_mcyc;
  logic                             r_bit_cmd, r_cb_next, r_cb_mode;
  logic                             w_stall, w_active, w_last, w_cc_false;
  logic                             w_cb_next, w_latch;
  logic [2:0]                       w_mcyc, w_last_idx;
  control_signals_t                 w_slot_ctrl;

`ifdef GB_CPU_SEQ_STALL_EN
  assign w_stall = stall_i;
`else
  assign w_stall = 1'b0;
`endif

  // Slot 0 runs straight off the decoder; later slots come from the latched copy.
  assign w_slot_ctrl = (r_idx == 3'd0) ? schedule_i.instruction_controls[0] : r_sched[r_idx];
  assign w_mcyc      = (r_idx == 3'd0) ? clamp_mcyc(schedule_i.m_cycles) : r_mcyc;
  assign w_cb_next   = (r_idx == 3'd0) ? schedule_i.cb_prefix_next : r_cb_next;
  assign w_last_idx  = w_mcyc - 3'd1;
  assign w_last      = (r_idx == w_last_idx);
  assign w_active    = (r_state == S_EXEC) && !w_stall;
  assign w_latch     = w_active && (r_idx == 3'd0);
  assign w_cc_false  = w_slot_ctrl.cc_check && !w_last
                       && !checkCondition(w_slot_ctrl.cond, flags_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    ctrl_o        = CTRL_NOP;
    instr_start_o = 1'b0;
    case (r_state)
      S_BOOT: begin
        ctrl_o      = CTRL_FETCH;
        w_state_nxt = S_EXEC;
        w_idx_nxt   = 3'd0;
      end
      S_EXEC: begin
        if (!w_stall) begin
          ctrl_o        = w_slot_ctrl;
          instr_start_o = (r_idx == 3'd0);
          if (w_last)          w_idx_nxt = 3'd0;
          else if (w_cc_false) w_idx_nxt = w_last_idx;
          else                 w_idx_nxt = r_idx + 3'd1;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
    if (!rst_n) ctrl_o = CTRL_NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sched   <= {MAX_SLOTS{CTRL_NOP}};
      r_mcyc    <= 3'd1;
      r_bit_cmd <= 1'b0;
      r_cb_next <= 1'b0;
      r_cb_mode <= 1'b0;
    end else begin
      if (w_latch) begin
        r_sched   <= schedule_i.instruction_controls;
        r_mcyc    <= clamp_mcyc(schedule_i.m_cycles);
        r_bit_cmd <= schedule_i.bit_cmd;
        r_cb_next <= schedule_i.cb_prefix_next;
      end
      // Prefix mode covers exactly the instruction after the one requesting it.
      if (w_active && w_last) r_cb_mode <= w_cb_next;
    end
  end

  gb_cpu_ime_ctrl u_ime (
    .clk        (clk),
    .rst_n      (rst_n),
    .ei         (w_active && w_slot_ctrl.enable_interrupts),
    .di         (w_active && w_slot_ctrl.disable_interrupts),
    .instr_last (w_active && w_last),
    .ime        (ime_o)
  );

  assign m_cycle_o = r_idx;
  assign cb_mode_o = r_cb_mode;
  assign bit_cmd_o = r_bit_cmd;

endmodule
`default_nettype wire

// File: tb/tb_gb_cpu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gb_cpu_sequencer
// Purpose  : Self-checking bench: vector table, directed corners, random model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gb_cpu_sequencer;
  import gb_cpu_common_pkg::*;

  localparam int CTRL_W = $bits(control_signals_t);
  localparam int NV     = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  schedule_t        schedule_i;
  logic [3:0]       flags_i;
  control_signals_t ctrl_o;
  logic             instr_start_o;
  logic [2:0]       m_cycle_o;
  logic             cb_mode_o, bit_cmd_o, ime_o;
`ifdef GB_CPU_SEQ_STALL_EN
  logic             stall_i;
`endif

  gb_cpu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .schedule_i    (schedule_i),
    .flags_i       (flags_i),
    .ctrl_o        (ctrl_o),
    .instr_start_o (instr_start_o),
    .m_cycle_o     (m_cycle_o),
    .cb_mode_o     (cb_mode_o),
    .bit_cmd_o     (bit_cmd_o),
    .ime_o         (ime_o)
`ifdef GB_CPU_SEQ_STALL_EN
    ,
    .stall_i       (stall_i)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Architectural model state, updated once per completed instruction.
  bit m_cb, m_ime, m_pend, m_prev_bit;

  typedef struct {
    logic [2:0]      mcyc;
    logic            cc0;
    condition_code_t cond;
    logic [3:0]      flags;
    logic [5:0]      mask;   // slots expected to execute, in ascending order
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampm(input logic [2:0] v);
    if (v == 3'd0) return 1;
    if (v > 3'd6) return 6;
    return int'(v);
  endfunction

  function automatic bit cond_true(input condition_code_t c, input logic [3:0] f);
    bit z, cy;
    z  = f[3];
    cy = f[0];
    if (c == COND_NZ) return !z;
    if (c == COND_Z)  return z;
    if (c == COND_NC) return !cy;
    return cy;
  endfunction

  function automatic control_signals_t rand_ctrl();
    logic [CTRL_W-1:0] r;
    r = CTRL_W'($urandom);
    return control_signals_t'(r);
  endfunction

  function automatic schedule_t rand_sched();
    schedule_t s;
    s.m_cycles = 3'($urandom);
    for (int k = 0; k < 6; k++) s.instruction_controls[k] = rand_ctrl();
    s.cb_prefix_next = 1'($urandom);
    s.bit_cmd        = 1'($urandom);
    return s;
  endfunction

  // Random instruction with EI/DI confined to the final slot.
  function automatic schedule_t rand_instr();
    schedule_t s;
    int        mm, sel;
    s  = rand_sched();
    mm = clampm(s.m_cycles);
    for (int k = 0; k < 6; k++) begin
      s.instruction_controls[k].enable_interrupts  = 1'b0;
      s.instruction_controls[k].disable_interrupts = 1'b0;
    end
    sel = int'($urandom_range(0, 7));
    if (sel == 0) s.instruction_controls[mm-1].enable_interrupts  = 1'b1;
    if (sel == 1) s.instruction_controls[mm-1].disable_interrupts = 1'b1;
    return s;
  endfunction

  function automatic schedule_t simple_instr(input logic [2:0] m, input bit ei, input bit di, input bit cbn);
    schedule_t s;
    int        mm;
    s = '0;
    s.m_cycles       = m;
    s.cb_prefix_next = cbn;
    for (int k = 0; k < 6; k++) begin
      s.instruction_controls[k]            = CTRL_NOP;
      s.instruction_controls[k].reg_wr_sel = 4'(k + 1);
      s.instruction_controls[k].reg_wren   = 1'b1;
    end
    mm = clampm(m);
    s.instruction_controls[mm-1].enable_interrupts  = ei;
    s.instruction_controls[mm-1].disable_interrupts = di;
    return s;
  endfunction

  // Entered just after a falling edge with the DUT at slot 0 of a new instruction.
  task automatic run_instr(input schedule_t s, input bit rnd_flags, input logic [3:0] fix_flags);
    int               m, i;
    bit               done;
    logic [3:0]       f;
    control_signals_t c;
    m    = clampm(s.m_cycles);
    i    = 0;
    done = 1'b0;
    while (!done) begin
      f          = rnd_flags ? 4'($urandom) : fix_flags;
      flags_i    = f;
      schedule_i = (i == 0) ? s : rand_sched();
      #2;
      c = s.instruction_controls[i];
      chk("ctrl", 32'(ctrl_o), 32'(c));
      chk("instr_start", 32'(instr_start_o), 32'(i == 0));
      chk("m_cycle", 32'(m_cycle_o), 32'(i));
      chk("cb_mode", 32'(cb_mode_o), 32'(m_cb));
      chk("ime", 32'(ime_o), 32'(m_ime));
      chk("bit_cmd", 32'(bit_cmd_o), 32'((i == 0) ? m_prev_bit : s.bit_cmd));
      if (i == m - 1) done = 1'b1;
      else if (c.cc_check && !cond_true(c.cond, f)) i = m - 1;
      else i++;
      @(negedge clk);
    end
    c = s.instruction_controls[m-1];
    if (c.disable_interrupts) begin
      m_ime  = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (m_pend) m_ime = 1'b1;
      m_pend = c.enable_interrupts;
    end
    m_cb       = s.cb_prefix_next;
    m_prev_bit = s.bit_cmd;
  endtask

  task automatic model_reset();
    m_cb = 1'b0; m_ime = 1'b0; m_pend = 1'b0; m_prev_bit = 1'b0;
  endtask

  initial begin
    schedule_t s;

    vecs[0]  = '{3'd3, 1'b0, COND_NZ, 4'b0000, 6'b000111};
    vecs[1]  = '{3'd3, 1'b1, COND_NZ, 4'b1000, 6'b000101};
    vecs[2]  = '{3'd3, 1'b1, COND_NZ, 4'b0000, 6'b000111};
    vecs[3]  = '{3'd0, 1'b0, COND_NZ, 4'b0000, 6'b000001};
    vecs[4]  = '{3'd7, 1'b0, COND_NZ, 4'b0000, 6'b111111};
    vecs[5]  = '{3'd6, 1'b1, COND_C,  4'b0001, 6'b111111};
    vecs[6]  = '{3'd6, 1'b1, COND_NC, 4'b0001, 6'b100001};
    vecs[7]  = '{3'd1, 1'b1, COND_Z,  4'b0000, 6'b000001};
    vecs[8]  = '{3'd2, 1'b1, COND_Z,  4'b1000, 6'b000011};
    vecs[9]  = '{3'd4, 1'b1, COND_Z,  4'b0000, 6'b001001};
    vecs[10] = '{3'd5, 1'b1, COND_C,  4'b0000, 6'b010001};

    rst_n      = 1'b0;
    schedule_i = '0;
    flags_i    = 4'd0;
`ifdef GB_CPU_SEQ_STALL_EN
    stall_i    = 1'b0;
`endif
    model_reset();

    #3;
    chk("rst_ctrl", 32'(ctrl_o), 32'(CTRL_NOP));
    chk("rst_ime", 32'(ime_o), 32'd0);
    chk("rst_m_cycle", 32'(m_cycle_o), 32'd0);
    chk("rst_cb_mode", 32'(cb_mode_o), 32'd0);
    chk("rst_bit_cmd", 32'(bit_cmd_o), 32'd0);
    chk("rst_instr_start", 32'(instr_start_o), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("boot_ctrl", 32'(ctrl_o), 32'(CTRL_FETCH));
    chk("boot_instr_start", 32'(instr_start_o), 32'd0);
    @(negedge clk);

    // Vector table: slot sequence per schedule under fixed flags.
    for (int v = 0; v < NV; v++) begin
      s = simple_instr(vecs[v].mcyc, 1'b0, 1'b0, 1'b0);
      s.instruction_controls[0].cc_check = vecs[v].cc0;
      s.instruction_controls[0].cond     = vecs[v].cond;
      s.bit_cmd = v[0];
      for (int k = 0; k < 6; k++) begin
        if (vecs[v].mask[k]) begin
          flags_i    = vecs[v].flags;
          schedule_i = (k == 0) ? s : rand_sched();
          #2;
          chk("vec_ctrl", 32'(ctrl_o), 32'(s.instruction_controls[k]));
          chk("vec_m_cycle", 32'(m_cycle_o), 32'(k));
          chk("vec_instr_start", 32'(instr_start_o), 32'(k == 0));
          chk("vec_bit_cmd", 32'(bit_cmd_o), 32'((k == 0) ? m_prev_bit : s.bit_cmd));
          @(negedge clk);
        end
      end
      m_cb       = 1'b0;
      m_prev_bit = s.bit_cmd;
    end

    // CB prefix: mode covers exactly the following instruction.
    run_instr(simple_instr(3'd1, 1'b0, 1'b0, 1'b0), 1'b0, 4'd0);
    run_instr(simple_instr(3'd1, 1'b0, 1'b0, 1'b1), 1'b0, 4'd0);
    #1 chk("cb_set", 32'(cb_mode_o), 32'd1);
    run_instr(simple_instr(3'd2, 1'b0, 1'b0, 1'b0), 1'b0, 4'd0);
    #1 chk("cb_clear", 32'(cb_mode_o), 32'd0);
    run_instr(simple_instr(3'd1, 1'b0, 1'b0, 1'b0), 1'b0, 4'd0);

    // EI delay: IME rises at the end of the instruction after EI.
    run_instr(simple_instr(3'd1, 1'b1, 1'b0, 1'b0), 1'b0, 4'd0);
    #1 chk("ime_after_ei", 32'(ime_o), 32'd0);
    run_instr(simple_instr(3'd1, 1'b0, 1'b0, 1'b0), 1'b0, 4'd0);
    #1 chk("ime_after_nop1", 32'(ime_o), 32'd1);
    run_instr(simple_instr(3'd1, 1'b0, 1'b0, 1'b0), 1'b0, 4'd0);

    // Reset in slot 1 aborts at once.
    s = simple_instr(3'd3, 1'b0, 1'b0, 1'b0);
    schedule_i = s;
    @(negedge clk);
    schedule_i = rand_sched();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'(ctrl_o), 32'(CTRL_NOP));
    chk("midrst_m_cycle", 32'(m_cycle_o), 32'd0);
    chk("midrst_ime", 32'(ime_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #2;
    chk("reboot_ctrl", 32'(ctrl_o), 32'(CTRL_FETCH));
    @(negedge clk);

    // EI immediately followed by DI leaves IME off.
    run_instr(simple_instr(3'd1, 1'b1, 1'b0, 1'b0), 1'b0, 4'd0);
    run_instr(simple_instr(3'd2, 1'b0, 1'b1, 1'b0), 1'b0, 4'd0);
    #1 chk("ime_ei_di", 32'(ime_o), 32'd0);
    run_instr(simple_instr(3'd1, 1'b0, 1'b0, 1'b0), 1'b0, 4'd0);
    #1 chk("ime_ei_di_later", 32'(ime_o), 32'd0);

`ifdef GB_CPU_SEQ_STALL_EN
    // Stall two cycles in slot 1; the pending cc_check must not fire meanwhile.
    s = simple_instr(3'd3, 1'b0, 1'b0, 1'b0);
    s.instruction_controls[1].cc_check = 1'b1;
    s.instruction_controls[1].cond     = COND_NZ;
    flags_i    = 4'b0000;
    schedule_i = s;
    #2 chk("stall_slot0", 32'(ctrl_o), 32'(s.instruction_controls[0]));
    @(negedge clk);
    schedule_i = rand_sched();
    stall_i    = 1'b1;
    flags_i    = 4'b1000;
    for (int n = 0; n < 2; n++) begin
      #2;
      chk("stall_ctrl", 32'(ctrl_o), 32'(CTRL_NOP));
      chk("stall_m_cycle", 32'(m_cycle_o), 32'd1);
      chk("stall_instr_start", 32'(instr_start_o), 32'd0);
      @(negedge clk);
    end
    stall_i = 1'b0;
    flags_i = 4'b0000;
    #2;
    chk("resume_slot1", 32'(ctrl_o), 32'(s.instruction_controls[1]));
    chk("resume_m_cycle1", 32'(m_cycle_o), 32'd1);
    @(negedge clk);
    #2;
    chk("resume_slot2", 32'(ctrl_o), 32'(s.instruction_controls[2]));
    chk("resume_m_cycle2", 32'(m_cycle_o), 32'd2);
    @(negedge clk);
    m_cb       = 1'b0;
    m_prev_bit = s.bit_cmd;
`endif

    // Random instruction stream against the instruction-level model.
    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(), 1'b1, 4'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
